// File: rtl/operand_fetcher.sv
// -----------------------------------------------------------------------------
// operand_fetcher
//
// Purpose:
//   Read-only burst engine that fetches pairs of operands from two memory
//   ports. Port A walks base_a, base_a+1, ...; port B walks base_b,
//   base_b+stride_b, ... (all 16-bit modulo). Each pair is captured in an
//   output register guarded by a valid/ready handshake.
//
// Ports:
//   clk, rst              : single clock, synchronous active-high reset
//   start                 : one-cycle burst request (ignored while busy)
//   base_a/base_b         : first address on port A / port B
//   stride_b              : port-B address increment per element
//   len                   : number of element pairs (0 is legal)
//   mem_addr_a/mem_addr_b : registered memory read addresses
//   mem_data_a/mem_data_b : combinational read data for those addresses
//   out_a/out_b/out_last  : registered pair and end-of-burst flag
//   out_valid/out_ready   : output handshake
//   busy, done, err       : status (done is a one-cycle completion pulse)
//
// Configuration:
//   BOUNDS_CHECK_EN : when defined, an address >= MEM_DEPTH seen at capture
//                     time sets a sticky err, drops the capture and ends the
//                     burst. When undefined, err is constant 0.
// -----------------------------------------------------------------------------
module operand_fetcher #(
   parameter int MEM_DEPTH = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] base_a,
   input  logic [15:0] base_b,
   input  logic [15:0] stride_b,
   input  logic [7:0]  len,
   output logic [15:0] mem_addr_a,
   output logic [15:0] mem_addr_b,
   input  logic [15:0] mem_data_a,
   input  logic [15:0] mem_data_b,
   output logic [15:0] out_a,
   output logic [15:0] out_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

`ifdef BOUNDS_CHECK_EN
   localparam logic LP_CHECK_EN = 1'b1;
`else
   localparam logic LP_CHECK_EN = 1'b0;
`endif

   localparam logic [16:0] LP_DEPTH = 17'(MEM_DEPTH);

   logic [1:0]  r_state;
   logic [15:0] r_addr_a;
   logic [15:0] r_addr_b;
   logic [15:0] r_stride;
   logic [7:0]  r_len;
   logic [7:0]  r_idx;
   logic [15:0] r_out_a;
   logic [15:0] r_out_b;
   logic        r_out_valid;
   logic        r_out_last;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic [1:0]  w_next_state;
   logic        w_advance;
   logic        w_last_idx;
   logic        w_oob_raw;
   logic        w_oob;

   // A new pair may be captured when the output slot is free or being drained.
   assign w_advance  = (r_state == S_FETCH) && (!r_out_valid || out_ready);
   assign w_last_idx = (r_idx == (r_len - 8'd1));
   assign w_oob_raw  = ({1'b0, r_addr_a} >= LP_DEPTH) || ({1'b0, r_addr_b} >= LP_DEPTH);
   // Checked only on an advance so a pair already waiting in the output
   // register is never discarded by the error path.
   assign w_oob      = LP_CHECK_EN & w_oob_raw;

   // Next-state selection for the burst sequencer.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (len != 8'd0) begin
                  w_next_state = S_FETCH;
               end else begin
                  w_next_state = S_FINISH;
               end
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_FETCH: begin
            if (w_advance) begin
               if (w_oob) begin
                  w_next_state = S_FINISH;
               end else if (w_last_idx) begin
                  w_next_state = S_DRAIN;
               end else begin
                  w_next_state = S_FETCH;
               end
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (r_out_valid && out_ready) begin
               w_next_state = S_FINISH;
            end else begin
               w_next_state = S_DRAIN;
            end
         end
         S_FINISH: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Sequencer state, address generation, output pair and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_addr_a    <= 16'd0;
         r_addr_b    <= 16'd0;
         r_stride    <= 16'd0;
         r_len       <= 8'd0;
         r_idx       <= 8'd0;
         r_out_a     <= 16'd0;
         r_out_b     <= 16'd0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != S_IDLE);
         r_done  <= (w_next_state == S_FINISH);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_stride <= stride_b;
                  r_len    <= len;
                  r_idx    <= 8'd0;
                  // The address registers double as the latched bases; an
                  // empty burst goes straight to FINISH with addresses at 0.
                  if (len != 8'd0) begin
                     r_addr_a <= base_a;
                     r_addr_b <= base_b;
                  end else begin
                     r_addr_a <= 16'd0;
                     r_addr_b <= 16'd0;
                  end
               end
            end
            S_FETCH: begin
               if (w_advance) begin
                  if (w_oob) begin
                     r_err       <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_addr_a    <= 16'd0;
                     r_addr_b    <= 16'd0;
                  end else begin
                     r_out_a     <= mem_data_a;
                     r_out_b     <= mem_data_b;
                     r_out_valid <= 1'b1;
                     r_out_last  <= w_last_idx;
                     r_idx       <= r_idx + 8'd1;
                     if (w_last_idx) begin
                        r_addr_a <= 16'd0;
                        r_addr_b <= 16'd0;
                     end else begin
                        r_addr_a <= r_addr_a + 16'd1;
                        r_addr_b <= r_addr_b + r_stride;
                     end
                  end
               end
            end
            S_DRAIN: begin
               if (r_out_valid && out_ready) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
               end
            end
            S_FINISH: begin
               r_idx <= 8'd0;
            end
            default: begin
               r_idx <= 8'd0;
            end
         endcase
      end
   end

   assign mem_addr_a = r_addr_a;
   assign mem_addr_b = r_addr_b;
   assign out_a      = r_out_a;
   assign out_b      = r_out_b;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;

endmodule

// File: tb/tb_operand_fetcher.sv
// -----------------------------------------------------------------------------
// tb_operand_fetcher
//
// Self-checking bench for operand_fetcher. Memory is a pure function of the
// address on each port. A reference model expands every burst request into the
// list of pairs it must produce; a monitor pops that list on each accepted
// pair and also checks that stalled outputs hold still.
// -----------------------------------------------------------------------------
module tb_operand_fetcher;

   localparam int TB_DEPTH = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] base_a;
   logic [15:0] base_b;
   logic [15:0] stride_b;
   logic [7:0]  len;
   logic [15:0] mem_addr_a;
   logic [15:0] mem_addr_b;
   logic [15:0] mem_data_a;
   logic [15:0] mem_data_b;
   logic [15:0] out_a;
   logic [15:0] out_b;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        err;

   int n_vec = 0;
   int n_err = 0;
   int n_done_total = 0;
   logic exp_err = 1'b0;
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   function automatic logic [15:0] fn_a(input logic [15:0] x);
      return (x * 16'd40503) ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] fn_b(input logic [15:0] x);
      return ({x[7:0], x[15:8]} ^ 16'hC3A5) + 16'd17;
   endfunction

   assign mem_data_a = fn_a(mem_addr_a);
   assign mem_data_b = fn_b(mem_addr_b);

   operand_fetcher #(.MEM_DEPTH(TB_DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start),
      .base_a(base_a), .base_b(base_b), .stride_b(stride_b), .len(len),
      .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
      .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
      .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .done(done), .err(err)
   );

   // Reference model: the pairs a burst must deliver, in order.
   function automatic void model_burst(input logic [15:0] ba, input logic [15:0] bb,
                                       input logic [15:0] st, input logic [7:0] ln);
      for (int i = 0; i < int'(ln); i++) begin
         logic [15:0] a;
         logic [15:0] b;
         a = ba + 16'(i);
         b = bb + 16'(i) * st;
`ifdef BOUNDS_CHECK_EN
         if (int'(a) >= TB_DEPTH || int'(b) >= TB_DEPTH) begin
            exp_err = 1'b1;
            break;
         end
`endif
         sb.push_back({fn_a(a), fn_b(b), (i == int'(ln) - 1)});
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: scoreboard pop on every handshake, hold check after a stall.
   logic        prev_stall = 1'b0;
   logic [15:0] prev_a, prev_b, prev_ma, prev_mb;
   logic        prev_last;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            n_vec++;
            if (!out_valid || out_a !== prev_a || out_b !== prev_b || out_last !== prev_last
                || mem_addr_a !== prev_ma || mem_addr_b !== prev_mb) begin
               n_err++;
               $display("FAIL hold: got v=%0b a=%h b=%h l=%0b ma=%h mb=%h expected v=1 a=%h b=%h l=%0b ma=%h mb=%h",
                        out_valid, out_a, out_b, out_last, mem_addr_a, mem_addr_b,
                        prev_a, prev_b, prev_last, prev_ma, prev_mb);
            end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL pair: got a=%h b=%h l=%0b expected no pair", out_a, out_b, out_last);
            end else begin
               logic [32:0] e;
               e = sb.pop_front();
               if ({out_a, out_b, out_last} !== e) begin
                  n_err++;
                  $display("FAIL pair: got a=%h b=%h l=%0b expected a=%h b=%h l=%0b",
                           out_a, out_b, out_last, e[32:17], e[16:1], e[0]);
               end
            end
         end
         if (done) n_done_total++;
         prev_stall = out_valid && !out_ready;
         prev_a  = out_a;
         prev_b  = out_b;
         prev_last = out_last;
         prev_ma = mem_addr_a;
         prev_mb = mem_addr_b;
      end
   end

   int done_base;

   // Drive a start request for one cycle; returns #1 after the sampling edge.
   task automatic start_burst(input logic [15:0] ba, input logic [15:0] bb,
                              input logic [15:0] st, input logic [7:0] ln);
      start = 1'b1; base_a = ba; base_b = bb; stride_b = st; len = ln;
      model_burst(ba, bb, st, ln);
      done_base = n_done_total;
      @(posedge clk); #1;
      start = 1'b0;
      base_a = 16'($urandom); base_b = 16'($urandom);
      stride_b = 16'($urandom); len = 8'($urandom);
   endtask

   task automatic wait_idle(input int budget, input bit rand_rdy);
      int cnt = 0;
      while (busy) begin
         if (cnt >= budget) begin
            n_vec++; n_err++;
            $display("FAIL timeout: got busy after %0d cycles expected idle", cnt);
            break;
         end
         if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         cnt++;
      end
      out_ready = 1'b1;
      chk("done_count", 32'(n_done_total - done_base), 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("err", 32'(err), 32'(exp_err));
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_last"},  32'(out_last), 32'd0);
      chk({nm, "_data"},  {out_a, out_b}, 32'd0);
      chk({nm, "_addr"},  {mem_addr_a, mem_addr_b}, 32'd0);
      chk({nm, "_stat"},  {29'd0, busy, done, err}, 32'd0);
   endtask

   initial begin
      logic [15:0] ba, bb, st;
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      base_a = 16'd0; base_b = 16'd0; stride_b = 16'd0; len = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic burst with a free-running consumer.
      start_burst(16'd0, 16'd100, 16'd1, 8'd4);
      chk("basic_addr_a", 32'(mem_addr_a), 32'd0);
      chk("basic_addr_b", 32'(mem_addr_b), 32'd100);
      chk("basic_busy", 32'(busy), 32'd1);
      chk("basic_nv", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("basic_v0", 32'(out_valid), 32'd1);
      chk("basic_nl0", 32'(out_last), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("basic_last", {31'd0, out_last}, 32'd1);
      @(posedge clk); #1;
      chk("basic_done", {30'd0, done, out_valid}, 32'd2);
      wait_idle(20, 1'b0);

      // Stride with two cycles of backpressure after the first valid.
      ba = 16'($urandom_range(0, 500));
      start_burst(ba, 16'd200, 16'd10, 8'd3);
      chk("bp_addr0", 32'(mem_addr_b), 32'd200);
      @(posedge clk); #1;
      chk("bp_v0", 32'(out_valid), 32'd1);
      out_ready = 1'b0;
      chk("bp_addr1", 32'(mem_addr_b), 32'd210);
      @(posedge clk); #1;
      chk("bp_hold_addr", 32'(mem_addr_b), 32'd210);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_addr2", 32'(mem_addr_b), 32'd220);
      wait_idle(20, 1'b0);

      // Empty burst.
      start_burst(16'd7, 16'd9, 16'd3, 8'd0);
      chk("len0_stat", {29'd0, busy, done, out_valid}, 32'd6);
      @(posedge clk); #1;
      chk("len0_idle", {30'd0, busy, done}, 32'd0);
      chk("len0_done_count", 32'(n_done_total - done_base), 32'd1);
      chk("len0_sb", 32'(sb.size()), 32'd0);

`ifndef BOUNDS_CHECK_EN
      // Port-A address wraps through 0xFFFF.
      start_burst(16'hFFFE, 16'd5, 16'd1, 8'd3);
      chk("wrap0", 32'(mem_addr_a), 32'h0000FFFE);
      @(posedge clk); #1;
      chk("wrap1", 32'(mem_addr_a), 32'h0000FFFF);
      @(posedge clk); #1;
      chk("wrap2", 32'(mem_addr_a), 32'h00000000);
      wait_idle(20, 1'b0);
`endif

      // Randomized bursts with a random consumer.
      for (int k = 0; k < 25; k++) begin
`ifdef BOUNDS_CHECK_EN
         ba = 16'($urandom_range(0, 1100));
         bb = 16'($urandom_range(0, 1100));
         st = 16'($urandom_range(0, 60));
`else
         ba = 16'($urandom);
         bb = 16'($urandom);
         st = 16'($urandom);
`endif
         start_burst(ba, bb, st, 8'($urandom_range(0, 12)));
         wait_idle(300, 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      // Reset in the middle of a burst, then restart immediately.
      start_burst(16'($urandom_range(0, 500)), 16'($urandom_range(0, 100)),
                  16'($urandom_range(0, 50)), 8'd8);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      exp_err = 1'b0;
      done_base = n_done_total;
      @(posedge clk); #1;
      chk_all_zero("midrst");
      rst = 1'b0;
      chk("midrst_nodone", 32'(n_done_total - done_base), 32'd0);
      start_burst(16'd50, 16'd60, 16'd2, 8'd5);
      chk("restart_addr", {mem_addr_a, mem_addr_b}, {16'd50, 16'd60});
      wait_idle(50, 1'b1);

`ifdef BOUNDS_CHECK_EN
      // Port A runs off the end of memory on the third element.
      start_burst(16'd998, 16'd0, 16'd1, 8'd4);
      wait_idle(30, 1'b0);
      chk("oob_err", 32'(err), 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("oob_sticky", 32'(err), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_err = 1'b0;
      chk("oob_cleared", 32'(err), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
